// File: rtl/updown_sweep_pkg.sv
// Shared types and defaults for the up/down counter sweep sequencer.
// Optional pause support is selected with the SWEEP_PAUSE_EN macro.
package updown_sweep_pkg;

    localparam int DEF_WIDTH      = 4;
    localparam int DEF_PRESCALE_W = 8;
    localparam int DEF_SWEEPS_W   = 8;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/updown_sweep_ctrl_if.sv
// Host-, config- and counter-side signals of the sweep sequencer, bundled.
// Port "pause" exists only when SWEEP_PAUSE_EN is defined.
interface updown_sweep_ctrl_if
    import updown_sweep_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W,
    parameter int SWEEPS_W   = DEF_SWEEPS_W
);
    logic                  start;
    logic                  stop;
`ifdef SWEEP_PAUSE_EN
    logic                  pause;
`endif
    logic [WIDTH-1:0]      lo_bound;
    logic [WIDTH-1:0]      hi_bound;
    logic [PRESCALE_W-1:0] prescale;
    logic [SWEEPS_W-1:0]   num_sweeps;
    logic [WIDTH-1:0]      cnt_in;
    logic                  cnt_load;
    logic [WIDTH-1:0]      cnt_load_val;
    logic                  cnt_enable;
    logic                  cnt_up_down;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [SWEEPS_W-1:0]   sweep_cnt;

    // master = host + counter side, slave = the sequencer
    modport master (
`ifdef SWEEP_PAUSE_EN
        output pause,
`endif
        output start, stop, lo_bound, hi_bound, prescale, num_sweeps, cnt_in,
        input  cnt_load, cnt_load_val, cnt_enable, cnt_up_down,
        input  busy, done, err, sweep_cnt
    );

    modport slave (
`ifdef SWEEP_PAUSE_EN
        input  pause,
`endif
        input  start, stop, lo_bound, hi_bound, prescale, num_sweeps, cnt_in,
        output cnt_load, cnt_load_val, cnt_enable, cnt_up_down,
        output busy, done, err, sweep_cnt
    );

endinterface

// File: rtl/updown_sweep_ctrl_prescaler.sv
// Modulo counter 0..i_limit with clear and hold; o_tick marks the terminal value.
// Hold freezes the count so a paused sweep resumes at the same phase.
module sweep_prescaler #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_hold,
    input  logic [W-1:0] i_limit,
    output logic         o_tick
);
    logic [W-1:0] r_cnt;

    assign o_tick = (r_cnt == i_limit);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= '0;
        end else if (!i_hold) begin
            r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Drives a 4-bit up/down counter through ping-pong sweeps between lo and hi.
// Define SWEEP_PAUSE_EN to add the pause input that stalls RUN.
module updown_sweep_ctrl
    import updown_sweep_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W,
    parameter int SWEEPS_W   = DEF_SWEEPS_W
) (
    input logic                clk,
    input logic                reset,
    updown_sweep_ctrl_if.slave bus
);
    state_t                r_state;
    state_t                w_next_state;
    logic                  r_dir;
    logic                  w_next_dir;
    logic [WIDTH-1:0]      r_lo;
    logic [WIDTH-1:0]      r_hi;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [SWEEPS_W-1:0]   r_num;
    logic [SWEEPS_W-1:0]   r_sweep_cnt;
    logic                  r_err;

    logic                  w_pause;
    logic                  w_tick;
    logic                  w_accept;
    logic                  w_reject;
    logic                  w_sweep_end;
    logic                  w_load;
    logic                  w_step;
    logic                  w_step_dir;
    logic [SWEEPS_W-1:0]   w_sweep_next;

`ifdef SWEEP_PAUSE_EN
    assign w_pause = bus.pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_sweep_next = r_sweep_cnt + 1'b1;

    sweep_prescaler #(.W(PRESCALE_W)) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .i_clear (r_state != RUN),
        .i_hold  (w_pause),
        .i_limit (r_prescale),
        .o_tick  (w_tick)
    );

    // NOTE: every output of this block gets a default first, so no latches.
    always_comb begin
        w_next_state = r_state;
        w_next_dir   = r_dir;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_sweep_end  = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_step_dir   = r_dir;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if ((bus.lo_bound < bus.hi_bound) && (bus.num_sweeps != '0)) begin
                        w_accept     = 1'b1;
                        w_next_state = LOAD;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (bus.stop) begin
                    w_next_state = IDLE;
                end else begin
                    w_load       = 1'b1;
                    w_next_dir   = DIR_UP;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                // stop beats a coincident tick; pause only freezes the tick
                if (bus.stop) begin
                    w_next_state = IDLE;
                end else if (w_tick && !w_pause) begin
                    if (r_dir == DIR_UP) begin
                        w_step = 1'b1;
                        if (bus.cnt_in >= r_hi) begin
                            w_next_dir = DIR_DOWN;
                            w_step_dir = DIR_DOWN;
                        end
                    end else if (bus.cnt_in > r_lo) begin
                        w_step = 1'b1;
                    end else begin
                        w_sweep_end = 1'b1;
                        if (w_sweep_next == r_num) begin
                            w_next_state = DONE;
                        end else begin
                            w_step     = 1'b1;
                            w_step_dir = DIR_UP;
                            w_next_dir = DIR_UP;
                        end
                    end
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_dir       <= DIR_UP;
            r_lo        <= '0;
            r_hi        <= '0;
            r_prescale  <= '0;
            r_num       <= '0;
            r_sweep_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_dir   <= w_next_dir;
            r_err   <= w_reject;
            if (w_accept) begin
                r_lo        <= bus.lo_bound;
                r_hi        <= bus.hi_bound;
                r_prescale  <= bus.prescale;
                r_num       <= bus.num_sweeps;
                r_sweep_cnt <= '0;
            end else if (w_sweep_end) begin
                r_sweep_cnt <= w_sweep_next;
            end
        end
    end

    // err is registered: it pulses the cycle after the rejected start
    assign bus.busy         = (r_state == LOAD) || (r_state == RUN);
    assign bus.done         = (r_state == DONE);
    assign bus.err          = r_err;
    assign bus.cnt_load     = w_load;
    assign bus.cnt_load_val = w_load ? r_lo : '0;
    assign bus.cnt_enable   = w_step;
    assign bus.cnt_up_down  = w_step & w_step_dir;
    assign bus.sweep_cnt    = r_sweep_cnt;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Self-checking bench for updown_sweep_ctrl with a behavioural 4-bit counter.
// Pause sequence is compiled in when SWEEP_PAUSE_EN is defined.
module tb_updown_sweep_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    updown_sweep_ctrl_if bus ();

    updown_sweep_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural model of the team's up/down counter
    logic [3:0] r_count;
    always @(posedge clk) begin
        if (reset)               r_count <= '0;
        else if (bus.cnt_load)   r_count <= bus.cnt_load_val;
        else if (bus.cnt_enable) r_count <= bus.cnt_up_down ? r_count + 4'd1 : r_count - 4'd1;
    end
    assign bus.cnt_in = r_count;

    typedef struct {
        int lo;
        int hi;
        int pre;
        int num;
        int ok;
        int exp_steps;
        int exp_lat;
    } vec_t;

    int exp_cnt_q[$];
    int exp_load_q[$];
    logic r_pending = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: count after every step, and the value of every load
    always @(negedge clk) begin
        if (r_pending) begin
            check("step_expected", int'(exp_cnt_q.size() > 0), 1);
            if (exp_cnt_q.size() > 0) check("count", int'(bus.cnt_in), exp_cnt_q.pop_front());
        end
        r_pending <= bus.cnt_enable && !reset;
        if (bus.cnt_load && !reset) begin
            check("load_expected", int'(exp_load_q.size() > 0), 1);
            if (exp_load_q.size() > 0) check("load_val", int'(bus.cnt_load_val), exp_load_q.pop_front());
            check("load_en_excl", int'(bus.cnt_enable), 0);
        end
    end

    task automatic push_expected(input int lo, input int hi, input int num);
        int c;
        c = lo;
        exp_load_q.push_back(lo);
        for (int s = 0; s < num; s++) begin
            for (int k = 0; k < hi - lo; k++) begin c++; exp_cnt_q.push_back(c); end
            for (int k = 0; k < hi - lo; k++) begin c--; exp_cnt_q.push_back(c); end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_cfg(input int lo, input int hi, input int pre, input int num);
        bus.lo_bound   = 4'(lo);
        bus.hi_bound   = 4'(hi);
        bus.prescale   = 8'(pre);
        bus.num_sweeps = 8'(num);
    endtask

    task automatic scramble_cfg();
        drive_cfg(int'($urandom_range(15)), int'($urandom_range(15)),
                  int'($urandom_range(3)), int'($urandom_range(3)));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},    int'(bus.busy), 0);
        check({tag, "_done"},    int'(bus.done), 0);
        check({tag, "_err"},     int'(bus.err), 0);
        check({tag, "_load"},    int'(bus.cnt_load), 0);
        check({tag, "_enable"},  int'(bus.cnt_enable), 0);
        check({tag, "_updown"},  int'(bus.cnt_up_down), 0);
        check({tag, "_loadval"}, int'(bus.cnt_load_val), 0);
        check({tag, "_sweeps"},  int'(bus.sweep_cnt), 0);
    endtask

    task automatic run_vec(input vec_t v);
        int n, en_cnt, err_cnt, last_en, gap_bad, busy_seen, load_seen, got_done, sweeps;
        en_cnt = 0; err_cnt = 0; last_en = -1; gap_bad = 0;
        busy_seen = 0; load_seen = 0; got_done = 0; sweeps = -1; n = 0;
        if (v.ok != 0) push_expected(v.lo, v.hi, v.num);
        drive_cfg(v.lo, v.hi, v.pre, v.num);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        scramble_cfg();
        if (v.ok != 0) begin
            for (n = 1; n <= v.exp_lat + 10; n++) begin
                @(negedge clk);
                if (bus.cnt_enable) begin
                    if (last_en >= 0 && n - last_en != v.pre + 1) gap_bad++;
                    last_en = n;
                    en_cnt++;
                end
                if (bus.err) err_cnt++;
                if (bus.done) begin
                    got_done = 1;
                    sweeps   = int'(bus.sweep_cnt);
                    break;
                end
            end
            check("done_seen", got_done, 1);
            check("done_latency", n, v.exp_lat);
            check("steps", en_cnt, v.exp_steps);
            check("step_gap", gap_bad, 0);
            check("run_err", err_cnt, 0);
            check("sweep_cnt", sweeps, v.num);
            check("queue_drained", exp_cnt_q.size(), 0);
            @(negedge clk);
            check("done_pulse", int'(bus.done), 0);
            check("idle_busy", int'(bus.busy), 0);
            check("sweep_hold", int'(bus.sweep_cnt), v.num);
        end else begin
            for (n = 1; n <= 3; n++) begin
                @(negedge clk);
                if (bus.err) err_cnt++;
                if (bus.busy) busy_seen = 1;
                if (bus.cnt_load) load_seen = 1;
            end
            check("err_pulses", err_cnt, 1);
            check("reject_busy", busy_seen, 0);
            check("reject_load", load_seen, 0);
        end
        exp_cnt_q.delete();
        exp_load_q.delete();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        int   found, n, err_cnt, got_done, lat;
        vecs[0] = '{2, 5, 0, 1, 1, 6, 9};
        vecs[1] = '{0, 3, 2, 2, 1, 12, 41};
        vecs[2] = '{7, 7, 0, 1, 0, 0, 0};
        vecs[3] = '{3, 9, 0, 0, 0, 0, 0};
        vecs[4] = '{9, 4, 1, 1, 0, 0, 0};
        vecs[5] = '{0, 15, 0, 1, 1, 30, 33};
        vecs[6] = '{14, 15, 3, 3, 1, 6, 30};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
`ifdef SWEEP_PAUSE_EN
        bus.pause = 1'b0;
`endif
        drive_cfg(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        step();

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // stop on a tick while count=4 going up
        push_expected(2, 6, 1);
        drive_cfg(2, 6, 0, 1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            step();
            if (bus.cnt_in == 4'd4) found = 1;
        end
        check("stop_reach", found, 1);
        bus.stop = 1'b1;
        @(negedge clk);
        check("stop_enable", int'(bus.cnt_enable), 0);
        check("stop_busy_same", int'(bus.busy), 1);
        step();
        bus.stop = 1'b0;
        exp_cnt_q.delete();
        exp_load_q.delete();
        got_done = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) got_done = 1;
        end
        check("stop_no_done_busy", got_done, 0);
        check("stop_count", int'(bus.cnt_in), 4);
        check("stop_sweeps", int'(bus.sweep_cnt), 0);
        step();

        // start while busy with an invalid config must be ignored
        push_expected(1, 4, 1);
        drive_cfg(1, 4, 0, 1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        err_cnt = 0; got_done = 0; lat = 0;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.err) err_cnt++;
            if (bus.done) begin got_done = 1; lat = n; break; end
            bus.start = (n == 3);
            if (n == 3) drive_cfg(5, 5, 0, 0);
        end
        bus.start = 1'b0;
        check("busy_start_done", got_done, 1);
        check("busy_start_latency", lat, 9);
        check("busy_start_err", err_cnt, 0);
        check("busy_start_sweeps", int'(bus.sweep_cnt), 1);
        exp_cnt_q.delete();
        exp_load_q.delete();
        step();
        step();

        // reset in RUN after one of three sweeps has completed
        push_expected(0, 2, 3);
        drive_cfg(0, 2, 0, 3);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (7) step();
        check("pre_reset_busy", int'(bus.busy), 1);
        check("pre_reset_sweeps", int'(bus.sweep_cnt), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_cnt_q.delete();
        exp_load_q.delete();
        @(negedge clk);
        check_idle_outputs("midrun_reset");
        step();

`ifdef SWEEP_PAUSE_EN
        // pause for 5 RUN cycles stretches the run by exactly 5 cycles
        push_expected(2, 5, 1);
        drive_cfg(2, 5, 0, 1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        err_cnt = 0; got_done = 0; lat = 0;
        for (n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (bus.pause && bus.cnt_enable) err_cnt++;
            if (bus.done) begin got_done = 1; lat = n; break; end
            bus.pause = (n >= 3 && n < 8);
        end
        bus.pause = 1'b0;
        check("pause_done", got_done, 1);
        check("pause_no_step", err_cnt, 0);
        check("pause_latency", lat, 14);
        check("pause_drained", exp_cnt_q.size(), 0);
        exp_cnt_q.delete();
        exp_load_q.delete();
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
Sequencer that drives the team's 4-bit up/down counter through programmable ping-pong sweeps between a low and a high bound.
- Owns the counter's load, load_val, enable and up_down inputs; reads back its count.
- Step rate set by a prescaler; sweep repeat count programmable.
- start/stop handshake plus busy/done status for a host FSM or CPU register block.

Parameters:
WIDTH, 4, counter width; matches the counter's count/load_val width
PRESCALE_W, 8, width of prescale config
SWEEPS_W, 8, width of num_sweeps config and sweep_cnt

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin sweeping; sampled only in IDLE
stop  input  1  abort; honoured in LOAD and RUN
lo_bound  input  WIDTH  lower sweep bound (unsigned)
hi_bound  input  WIDTH  upper sweep bound (unsigned)
prescale  input  PRESCALE_W  counter steps once every prescale+1 cycles
num_sweeps  input  SWEEPS_W  number of full lo->hi->lo round trips
cnt_in  input  WIDTH  counter's current count
cnt_load  output  1  to counter load
cnt_load_val  output  WIDTH  to counter load_val
cnt_enable  output  1  to counter enable
cnt_up_down  output  1  to counter up_down (1 = up)
busy  output  1  high in LOAD and RUN
done  output  1  one-cycle pulse on normal completion
err  output  1  one-cycle pulse when start is rejected
sweep_cnt  output  SWEEPS_W  completed sweeps in current run

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset: state=IDLE; cnt_load, cnt_enable, cnt_up_down, busy, done, err = 0; cnt_load_val = 0; sweep_cnt = 0; internal dir = up; prescaler = 0.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - start with lo_bound < hi_bound and num_sweeps != 0: latch lo/hi/prescale/num_sweeps, clear sweep_cnt, go to LOAD.
  - start otherwise: err=1 for one cycle, stay in IDLE.
- LOAD (1 cycle):
  - cnt_load=1, cnt_load_val=lo_q.
  - Next state RUN; dir=up; prescaler=0.
- RUN:
  - Prescaler counts 0..prescale_q; tick when it equals prescale_q, then it wraps to 0.
  - On tick, with v = cnt_in:
    - up and v < hi_q: step up.
    - up and v >= hi_q: dir<=down; step down the same cycle.
    - down and v > lo_q: step down.
    - down and v <= lo_q: sweep complete; sweep_cnt++. If new count == num_sweeps_q: go to DONE, no step. Else dir<=up and step up.
  - Step = cnt_enable=1 for one cycle, with cnt_up_down = direction of that step.
- DONE (1 cycle): done=1; cnt_enable=0; go to IDLE. sweep_cnt holds its value until the next accepted start.
- Timing: each sweep takes 2*(hi-lo) steps, i.e. 2*(hi-lo)*(prescale+1) RUN cycles. The counter updates on the edge after cnt_enable; cnt_in is valid at the next tick even with prescale=0.
- cnt_load/cnt_enable are combinational decodes of registered state/prescaler/dir and cnt_in. Never both high.
- stop in LOAD or RUN:
  - cnt_load and cnt_enable forced 0 that cycle.
  - Next state IDLE; no done.
  - sweep_cnt keeps its partial value.
- stop wins over a simultaneous tick. start while busy is ignored, with no err.
- reset mid-run: immediate return to reset values on that edge.
- Config inputs may change during RUN without effect (latched copies used).

Optional Feature:
SWEEP_PAUSE_EN
- Defined: adds input pause (1 bit). While pause=1 in RUN: prescaler frozen, cnt_enable=0, state and dir held. Deasserting resumes at the frozen prescaler value. stop overrides pause. pause is ignored in other states.
- Undefined: no pause port; RUN never stalls.

Decomposition:
- Package updown_sweep_pkg:
  - state enum typedef (IDLE, LOAD, RUN, DONE).
  - DIR_UP=1 / DIR_DOWN=0 constants.
  - Default WIDTH/PRESCALE_W/SWEEPS_W localparams.
- One sub-module, sweep_prescaler:
  - Loadable modulo counter with clear, hold and tick output.
  - Reused for the pause feature.

Test Plan:
- lo=2, hi=5, prescale=0, num_sweeps=1, start: cnt_load one cycle with val 2; count sequence 3,4,5,4,3,2 on consecutive cycles; done 1 cycle after count returns to 2 (next tick); sweep_cnt=1.
- lo=0, hi=3, prescale=2, num_sweeps=2: cnt_enable every 3rd RUN cycle; 12 steps total; done once; sweep_cnt=2.
- start with lo=7, hi=7, and again with num_sweeps=0: err pulse each time; busy stays 0; no cnt_load.
- stop asserted on a tick cycle mid-sweep (count=4, going up): cnt_enable=0 that cycle; busy drops next cycle; no done; count stays 4; sweep_cnt unchanged.
- reset asserted in RUN, and start pulsed while busy: reset returns all outputs to reset values next edge; start while busy has no effect on the sequence.
- With SWEEP_PAUSE_EN: pause high 5 cycles mid-RUN: no cnt_enable during pause; total run length extended by exactly 5 cycles.
